// File: rtl/tt_eval_seq.sv
// Runtime-loadable N-input truth-table evaluator with valid/ready handshake.
// The table streams in MSB first through a shadow register and commits atomically on the last bit.
module tt_eval_seq #(
  parameter int unsigned          N_IN       = 3,
  parameter logic [(1<<N_IN)-1:0] TT_INIT    = '0,
  parameter bit                   INIT_VALID = 1'b0,
  parameter int unsigned          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_done,
  output logic             cfg_busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [CNT_W-1:0] eval_cnt
);

  // state    | meaning
  // ST_UNCFG | no usable table yet; inputs are refused
  // ST_LOAD  | table bits are shifting into the shadow register
  // ST_RUN   | active table valid; vectors are evaluated
  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int unsigned TT_W      = 1 << N_IN;
  localparam state_t      RST_STATE = INIT_VALID ? ST_RUN : ST_UNCFG;

  state_t            state_q, state_d;
  logic [TT_W-1:0]   shadow_q, shadow_d;
  logic [TT_W-1:0]   table_q, table_d;
  logic [N_IN-1:0]   bit_cnt_q, bit_cnt_d;
  logic              cfg_done_q;
  logic              out_valid_q, out_valid_d;
  logic              out_bit_q, out_bit_d;
  logic [CNT_W-1:0]  eval_cnt_q, eval_cnt_d;

  logic              cfg_take;
  logic              commit;
  logic              accept;
  logic              handshake;
  logic [N_IN-1:0]   tt_idx;

  // cfg_start has priority over a coincident config bit
  assign cfg_take  = (state_q == ST_LOAD) && cfg_valid && !cfg_start;
  // The counter covers exactly TT_W bits, so all-ones marks the final bit
  assign commit    = cfg_take && (&bit_cnt_q);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;
  // Row 0 sits at the table MSB, so bit index TT_W-1-r equals the inverted row number
  assign tt_idx    = ~in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNCFG: if (cfg_start) state_d = ST_LOAD;
      ST_LOAD:  if (commit)    state_d = ST_RUN;
      ST_RUN:   if (cfg_start) state_d = ST_LOAD;
      default:                 state_d = RST_STATE;
    endcase
  end

  always_comb begin
    cfg_busy = (state_q == ST_LOAD);
    in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  end

  always_comb begin
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    table_d   = table_q;
    if (cfg_start) begin
      shadow_d  = '0;
      bit_cnt_d = '0;
    end else if (cfg_take) begin
      shadow_d  = {shadow_q[TT_W-2:0], cfg_bit};
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (commit) begin
        table_d = {shadow_q[TT_W-2:0], cfg_bit};
      end
    end
  end

  // A held result keeps its value even if a new table commits underneath it
  always_comb begin
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_bit_d   = table_q[tt_idx];
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    eval_cnt_d = eval_cnt_q;
    if (commit) begin
      eval_cnt_d = '0;
    end else if (handshake && (eval_cnt_q != {CNT_W{1'b1}})) begin
      eval_cnt_d = eval_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      table_q     <= TT_INIT;
      cfg_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      eval_cnt_q  <= '0;
    end else begin
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      table_q     <= table_d;
      cfg_done_q  <= commit;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      eval_cnt_q  <= eval_cnt_d;
    end
  end

  assign cfg_done  = cfg_done_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign eval_cnt  = eval_cnt_q;

endmodule

// File: tb/tb_tt_eval_seq.sv
// Bench for tt_eval_seq: directed load/evaluate scenarios plus random traffic against a table model.
// A second instance covers reset into RUN with a preset table.
module tb_tt_eval_seq;

  logic        clk = 1'b0;
  logic        rst_n, cfg_start, cfg_valid, cfg_bit, cfg_done, cfg_busy;
  logic        in_valid, in_ready, out_valid, out_ready, out_bit;
  logic [2:0]  in_data;
  logic [15:0] eval_cnt;

  logic        rst_n_b, cfg_start_b, cfg_valid_b, cfg_bit_b, cfg_done_b, cfg_busy_b;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_bit_b;
  logic [2:0]  in_data_b;
  logic [15:0] eval_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tt_eval_seq #(.N_IN(3), .TT_INIT(8'h00), .INIT_VALID(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_done(cfg_done), .cfg_busy(cfg_busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .eval_cnt(eval_cnt)
  );

  tt_eval_seq #(.N_IN(3), .TT_INIT(8'h0F), .INIT_VALID(1'b1), .CNT_W(16)) dut_iv (
    .clk(clk), .rst_n(rst_n_b), .cfg_start(cfg_start_b), .cfg_valid(cfg_valid_b), .cfg_bit(cfg_bit_b),
    .cfg_done(cfg_done_b), .cfg_busy(cfg_busy_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_bit(out_bit_b),
    .eval_cnt(eval_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: mode, bits collected so far, table as an integer, one-slot output buffer.
  localparam int M_UNCFG = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;

  int          m_mode;
  int          m_nbits;
  int unsigned m_shadow, m_tbl, m_cnt;
  bit          m_has_out, m_out, m_done;

  task automatic m_reset();
    m_mode = M_UNCFG; m_nbits = 0; m_shadow = 0; m_tbl = 0; m_cnt = 0;
    m_has_out = 0; m_out = 0; m_done = 0;
  endtask

  function automatic bit exp_ready();
    return (m_mode == M_RUN) && (!m_has_out || out_ready);
  endfunction

  task automatic m_step();
    bit          acc, hs, commit;
    int unsigned new_tbl;
    acc     = in_valid && exp_ready();
    hs      = m_has_out && out_ready;
    commit  = 0;
    new_tbl = m_tbl;
    if (m_mode == M_LOAD) begin
      if (cfg_start) begin
        m_nbits = 0;
      end else if (cfg_valid) begin
        m_shadow = ((m_shadow << 1) | 32'(cfg_bit)) & 32'hFF;
        m_nbits++;
        if (m_nbits == 8) begin
          commit  = 1;
          new_tbl = m_shadow;
          m_mode  = M_RUN;
          m_nbits = 0;
        end
      end
    end else if (cfg_start) begin
      m_mode  = M_LOAD;
      m_nbits = 0;
    end
    if (acc) begin
      m_has_out = 1;
      m_out     = 1'((m_tbl >> (7 - 32'(in_data))) & 1);
    end else if (hs) begin
      m_has_out = 0;
    end
    if (commit) m_cnt = 0;
    else if (hs && m_cnt < 65535) m_cnt++;
    m_done = commit;
    m_tbl  = new_tbl;
  endtask

  // Called at a falling edge with inputs already driven; advances one clock and checks everything.
  task automatic cyc(input string tag);
    #1;
    chk({tag, "/in_ready"}, 32'(in_ready), 32'(exp_ready()));
    @(posedge clk);
    m_step();
    #1;
    chk({tag, "/out_valid"}, 32'(out_valid), 32'(m_has_out));
    if (m_has_out) chk({tag, "/out_bit"}, 32'(out_bit), 32'(m_out));
    chk({tag, "/eval_cnt"}, 32'(eval_cnt), m_cnt);
    chk({tag, "/cfg_done"}, 32'(cfg_done), 32'(m_done));
    chk({tag, "/cfg_busy"}, 32'(cfg_busy), 32'(m_mode == M_LOAD));
    @(negedge clk);
  endtask

  task automatic idle();
    cfg_start = 0; cfg_valid = 0; cfg_bit = 0; in_valid = 0; in_data = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #1;
    chk("rst/out_valid", 32'(out_valid), 0);
    chk("rst/out_bit",   32'(out_bit),   0);
    chk("rst/cfg_busy",  32'(cfg_busy),  0);
    chk("rst/cfg_done",  32'(cfg_done),  0);
    chk("rst/eval_cnt",  32'(eval_cnt),  0);
    chk("rst/in_ready",  32'(in_ready),  0);
    m_reset();
    #2 rst_n = 1;
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] t);
    cfg_start = 1; cfg_valid = 0;
    cyc("load_start");
    cfg_start = 0;
    for (int i = 7; i >= 0; i--) begin
      cfg_valid = 1;
      cfg_bit   = t[i];
      cyc("load_bit");
    end
    cfg_valid = 0;
    chk("load/cfg_done", 32'(cfg_done), 1);
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 0; rst_n_b = 0;
    cfg_start_b = 0; cfg_valid_b = 0; cfg_bit_b = 0; in_valid_b = 0; in_data_b = 0; out_ready_b = 0;
    idle();
    @(negedge clk);
    do_reset();

    // Unconfigured: offered vectors are refused
    in_valid = 1; in_data = 3'd5; out_ready = 1;
    cyc("uncfg"); cyc("uncfg");
    chk("uncfg/out_valid", 32'(out_valid), 0);
    idle();

    // Load 1,0,0,1,1,0,1,0 and sweep all rows
    pat = 8'b1001_1010;
    load(pat);
    cyc("done_clear");
    chk("done_clear/cfg_done", 32'(cfg_done), 0);
    out_ready = 1;
    for (int r = 0; r < 8; r++) begin
      in_valid = 1; in_data = 3'(r);
      cyc("sweep");
      chk("sweep/out_bit", 32'(out_bit), 32'(pat[7-r]));
    end
    in_valid = 0;
    cyc("sweep_drain");
    chk("sweep/eval_cnt", 32'(eval_cnt), 8);

    // Backpressure: held result stays put, then exactly one handshake
    in_valid = 1; in_data = 3'd0;
    cyc("bp_acc");
    out_ready = 0; in_data = 3'd1;
    for (int i = 0; i < 5; i++) begin
      cyc("bp_hold");
      chk("bp_hold/out_bit", 32'(out_bit), 1);
      chk("bp_hold/in_ready", 32'(in_ready), 0);
    end
    out_ready = 1; in_valid = 0;
    cyc("bp_release");
    chk("bp_release/eval_cnt", 32'(eval_cnt), 9);
    cyc("bp_empty");
    chk("bp_empty/out_valid", 32'(out_valid), 0);

    // Reload while a result computed from the old table is held
    load(8'h00);
    in_valid = 1; in_data = 3'd5; out_ready = 0;
    cyc("hold_acc");
    in_valid = 0;
    load(8'hFF);
    chk("reload/out_bit",   32'(out_bit),   0);
    chk("reload/out_valid", 32'(out_valid), 1);
    chk("reload/eval_cnt",  32'(eval_cnt),  0);
    in_valid = 1; in_data = 3'd5; out_ready = 1;
    cyc("reload_next");
    chk("reload_next/out_bit", 32'(out_bit), 1);
    in_valid = 0;
    cyc("reload_drain");

    // Abort after 5 bits (restart with a coincident bit that must be dropped), then load 0xE8.
    // Row 0 is the MSB, so row 3 reads bit 4 (0) and row 4 reads bit 3 (1).
    cfg_start = 1;
    cyc("abort_start");
    cfg_start = 0;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1; cfg_bit = 1'($urandom_range(0, 1));
      cyc("abort_bit");
    end
    cfg_start = 1; cfg_valid = 1; cfg_bit = 1;
    cyc("abort_restart");
    cfg_valid = 0;
    load(8'hE8);
    in_valid = 1; in_data = 3'b011;
    cyc("e8_row3");
    chk("e8_row3/out_bit", 32'(out_bit), 0);
    in_data = 3'b100;
    cyc("e8_row4");
    chk("e8_row4/out_bit", 32'(out_bit), 1);
    in_valid = 0;
    cyc("e8_drain");

    // Random traffic, with an async reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_start = ($urandom_range(0, 49) == 0);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_bit   = 1'($urandom_range(0, 1));
      cyc("rand");
    end
    idle();

    // Preset-table instance: reset mid-load returns to RUN with 0x0F
    rst_n_b = 1;
    @(negedge clk);
    chk("iv/in_ready", 32'(in_ready_b), 1);
    cfg_start_b = 1;
    @(negedge clk);
    cfg_start_b = 0;
    chk("iv/busy", 32'(cfg_busy_b), 1);
    cfg_valid_b = 1; cfg_bit_b = 1;
    repeat (3) @(negedge clk);
    rst_n_b = 0;
    #1;
    chk("iv_rst/cfg_busy",  32'(cfg_busy_b),  0);
    chk("iv_rst/in_ready",  32'(in_ready_b),  1);
    chk("iv_rst/out_valid", 32'(out_valid_b), 0);
    cfg_valid_b = 0; cfg_bit_b = 0;
    #2 rst_n_b = 1;
    @(negedge clk);
    in_valid_b = 1; in_data_b = 3'b100; out_ready_b = 1;
    @(negedge clk);
    chk("iv/row4_valid", 32'(out_valid_b), 1);
    chk("iv/row4", 32'(out_bit_b), 1);
    in_data_b = 3'b000;
    @(negedge clk);
    chk("iv/row0", 32'(out_bit_b), 0);
    chk("iv/cnt1", 32'(eval_cnt_b), 1);
    in_valid_b = 0;
    @(negedge clk);
    chk("iv/cnt2", 32'(eval_cnt_b), 2);
    chk("iv/empty", 32'(out_valid_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
